// File: rtl/crc_ahb_slave.sv
// crc_ahb_slave: AHB-Lite slave feeding payload bytes into a programmable byte-serial CRC-32 engine
module crc_ahb_slave #(
  parameter int          ADDR_W   = 20,
  parameter logic [31:0] POLY_RST = 32'h04C11DB7,
  parameter logic [31:0] INIT_RST = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_RST  = 32'hFFFFFFFF
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [1:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);
  logic [31:0] crc, poly, init, xorout, buffer, lanes;
  logic [2:0]  cnt, k, rsel;
  logic [4:0]  p_addr;
  logic [1:0]  p_size;
  logic        pend, p_write, busy, done, wr, word_wr, unused;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [31:0] p, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {b, 24'h0};
    for (int i = 0; i < 8; i++) r = r[31] ? (r << 1) ^ p : r << 1;
    return r;
  endfunction

  assign unused    = ^{HADDR[ADDR_W-1:5], HTRANS[0]};
  assign busy      = cnt != 3'd0;
  assign done      = pend & ~busy;
  assign wr        = done & p_write;
  assign word_wr   = wr & (p_size == 2'd2);
  assign rsel      = p_addr[4:2];
  assign HREADYOUT = ~(pend & busy);
  assign HRESP     = 1'b0;
  assign lanes     = p_size == 2'd0 ? HWDATA >> {p_addr[1:0], 3'b000} :
                     p_size == 2'd1 ? HWDATA >> {p_addr[1], 4'b0000} : HWDATA;
  assign k         = p_size == 2'd0 ? 3'd1 : p_size == 2'd1 ? 3'd2 : 3'd4;

  // read data only while a read data phase is completing
  always_comb
    HRDATA = !(done & ~p_write) ? 32'h0 :
             rsel == 3'd1 ? crc ^ xorout :
             rsel == 3'd2 ? poly :
             rsel == 3'd3 ? init :
             rsel == 3'd4 ? {30'h0, busy, 1'b0} :
             rsel == 3'd5 ? xorout : 32'h0;

  // capture address phase; a stalled data phase holds until the engine drains
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pend    <= 1'b0;
      p_addr  <= 5'h0;
      p_write <= 1'b0;
      p_size  <= 2'd0;
    end else if (HREADY) begin
      pend    <= HSEL & HTRANS[1];
      p_addr  <= HADDR[4:0];
      p_write <= HWRITE;
      p_size  <= HSIZE;
    end else if (done) begin
      pend    <= 1'b0;
    end
  end

  // register writes and LOAD on completion; one payload byte folded per busy cycle
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      crc    <= INIT_RST;
      poly   <= POLY_RST;
      init   <= INIT_RST;
      xorout <= XOR_RST;
      buffer <= 32'h0;
      cnt    <= 3'd0;
    end else begin
      if (busy) begin
        crc    <= crc_byte(crc, poly, buffer[7:0]);
        buffer <= buffer >> 8;
        cnt    <= cnt - 3'd1;
      end
      if (wr & (rsel == 3'd0)) begin
        buffer <= lanes;
        cnt    <= k;
      end
      if (word_wr & (rsel == 3'd2)) poly <= HWDATA;
      if (word_wr & (rsel == 3'd3)) init <= HWDATA;
      if (word_wr & (rsel == 3'd4) & HWDATA[0]) crc <= init;
      if (word_wr & (rsel == 3'd5)) xorout <= HWDATA;
    end
  end
endmodule

// File: tb/tb_crc_ahb_slave.sv
// tb_crc_ahb_slave: table-driven pipelined AHB transfers against hand-computed CRC results
module tb_crc_ahb_slave;
  logic        HCLK = 1'b0, HRESET = 1'b1, HSEL = 1'b0, HWRITE = 1'b0, hready_ext = 1'b1;
  logic [19:0] HADDR = 20'h0;
  logic [1:0]  HTRANS = 2'b00, HSIZE = 2'd0;
  logic [31:0] HWDATA = 32'h0, HRDATA;
  logic        HREADY, HREADYOUT, HRESP;
  logic        hresp_bad = 1'b0;
  int          n_chk = 0, n_fail = 0;

  typedef struct {
    logic        w;
    logic [4:0]  a;
    logic [1:0]  sz;
    logic [31:0] d;
    logic        chk;
    logic [31:0] exp;
    int          ws;
    logic        brk;
  } op_t;
  op_t vec[$];

  assign HREADY = HREADYOUT & hready_ext;
  always #5 HCLK = ~HCLK;

  crc_ahb_slave dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
  );

  always @(negedge HCLK) if (HRESP !== 1'b0) hresp_bad = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mcrc(input logic [31:0] c, input logic [31:0] p, input logic [7:0] b);
    for (int i = 7; i >= 0; i--) c = {c[30:0], 1'b0} ^ ((c[31] ^ b[i]) ? p : 32'h0);
    return c;
  endfunction

  task automatic wr(input logic [4:0] a, input logic [1:0] sz, input logic [31:0] d, input int ws, input logic brk);
    op_t o;
    o.w = 1'b1; o.a = a; o.sz = sz; o.d = d; o.chk = 1'b0; o.exp = 32'h0; o.ws = ws; o.brk = brk;
    vec.push_back(o);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input int ws, input logic brk);
    op_t o;
    o.w = 1'b0; o.a = a; o.sz = 2'd2; o.d = 32'h0; o.chk = 1'b1; o.exp = exp; o.ws = ws; o.brk = brk;
    vec.push_back(o);
  endtask

  task automatic run(input int lo, input int hi);
    int ap, dp, w, cyc;
    logic rdy, pres;
    ap = lo; dp = -1; w = 0; cyc = 0;
    while ((dp >= 0 || ap <= hi) && cyc < 2000) begin
      @(negedge HCLK);
      cyc++;
      pres   = ap <= hi && !(dp >= 0 && vec[dp].brk);
      HWDATA = dp >= 0 ? vec[dp].d : 32'h0;
      HSEL   = pres;
      HTRANS = pres ? 2'b10 : 2'b00;
      if (pres) begin
        HADDR  = 20'(vec[ap].a);
        HWRITE = vec[ap].w;
        HSIZE  = vec[ap].sz;
      end
      #1;
      rdy = HREADYOUT;
      if (dp >= 0 && rdy) begin
        if (vec[dp].chk) check($sformatf("op%0d_rdata", dp), HRDATA, vec[dp].exp);
        if (vec[dp].ws >= 0) check($sformatf("op%0d_waits", dp), w, vec[dp].ws);
      end
      @(posedge HCLK);
      if (rdy) begin
        dp = pres ? ap : -1;
        ap += pres ? 1 : 0;
        w = 0;
      end else w++;
    end
    check($sformatf("run%0d_complete", lo), 32'(dp < 0 && ap > hi), 32'd1);
  endtask

  initial begin
    logic [31:0] m4, ma;
    int main_end, r0, r1, r2, r3;
    m4 = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) m4 = mcrc(m4, 32'h04C11DB7, 8'h31 + 8'(i));
    ma = mcrc(32'h12345678, 32'h1EDC6F41, 8'hA5);
    rd(5'h04, 32'h00000000, 0, 0);
    rd(5'h08, 32'h04C11DB7, 0, 0);
    rd(5'h10, 32'h00000000, 0, 0);
    rd(5'h14, 32'hFFFFFFFF, 0, 0);
    rd(5'h0C, 32'hFFFFFFFF, 0, 0);
    rd(5'h00, 32'h00000000, 0, 1);
    for (int i = 0; i < 9; i++) wr(5'h00, 2'd0, 32'h31 + 32'(i), i == 0 ? 0 : 1, 0);
    rd(5'h04, 32'hFC891918, 1, 1);
    wr(5'h14, 2'd2, 32'h0, 0, 0);
    wr(5'h10, 2'd2, 32'h1, 0, 0);
    wr(5'h00, 2'd2, 32'h34333231, 0, 0);
    wr(5'h00, 2'd2, 32'h38373635, 4, 0);
    wr(5'h03, 2'd0, 32'h39000000, 4, 0);
    rd(5'h04, 32'h0376E6E7, 1, 1);
    wr(5'h10, 2'd2, 32'h1, 0, 0);
    wr(5'h00, 2'd1, 32'h00003231, 0, 0);
    wr(5'h02, 2'd1, 32'h34330000, 2, 0);
    rd(5'h04, m4, 2, 1);
    wr(5'h10, 2'd2, 32'h1, 0, 0);
    for (int i = 0; i < 4; i++) wr(5'h00, 2'd0, 32'h31 + 32'(i), i == 0 ? 0 : 1, 0);
    rd(5'h04, m4, 1, 1);
    wr(5'h04, 2'd2, 32'h12345678, 0, 0);
    rd(5'h04, m4, 0, 0);
    wr(5'h08, 2'd0, 32'h12345678, 0, 0);
    rd(5'h08, 32'h04C11DB7, 0, 0);
    wr(5'h18, 2'd2, 32'hFFFFFFFF, 0, 0);
    rd(5'h18, 32'h0, 0, 0);
    rd(5'h00, 32'h0, 0, 0);
    wr(5'h00, 2'd2, 32'h34333231, 0, 0);
    wr(5'h10, 2'd2, 32'h1, 4, 0);
    rd(5'h04, 32'hFFFFFFFF, 0, 0);
    rd(5'h10, 32'h0, 0, 0);
    wr(5'h0C, 2'd2, 32'h12345678, 0, 0);
    wr(5'h10, 2'd2, 32'h1, 0, 0);
    rd(5'h04, 32'h12345678, 0, 0);
    wr(5'h08, 2'd2, 32'h1EDC6F41, 0, 0);
    wr(5'h01, 2'd0, 32'h0000A500, 0, 0);
    rd(5'h04, ma, 1, 0);
    wr(5'h10, 2'd1, 32'h1, 0, 0);
    rd(5'h04, ma, 0, 0);
    rd(5'h08, 32'h1EDC6F41, 0, 1);
    main_end = vec.size() - 1;
    r0 = vec.size();
    wr(5'h00, 2'd2, 32'h34333231, -1, 1);
    r1 = vec.size();
    rd(5'h10, 32'h0, 0, 0);
    rd(5'h04, 32'h0, 0, 0);
    rd(5'h08, 32'h04C11DB7, 0, 0);
    rd(5'h14, 32'hFFFFFFFF, 0, 0);
    rd(5'h0C, 32'hFFFFFFFF, 0, 1);
    r2 = vec.size() - 1;
    r3 = vec.size();
    rd(5'h08, 32'h04C11DB7, 0, 1);
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    #1;
    check("reset_hreadyout", HREADYOUT, 1'b1);
    check("reset_hrdata", HRDATA, 32'h0);
    run(0, main_end);
    run(r0, r0);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 20'h04; HSIZE = 2'd2;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HRESET = 1'b1;
    #1;
    check("stall_before_reset", HREADYOUT, 1'b0);
    @(negedge HCLK);
    HRESET = 1'b0;
    #1;
    check("ready_after_reset", HREADYOUT, 1'b1);
    check("rdata_after_reset", HRDATA, 32'h0);
    run(r1, r2);
    @(negedge HCLK);
    hready_ext = 1'b0; HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 20'h08; HSIZE = 2'd2;
    #1;
    check("hready_low_ready", HREADYOUT, 1'b1);
    @(negedge HCLK);
    hready_ext = 1'b1; HTRANS = 2'b00; HWDATA = 32'hDEADBEEF;
    #1;
    check("idle_dphase_ready", HREADYOUT, 1'b1);
    @(negedge HCLK);
    HSEL = 1'b0;
    run(r3, r3);
    check("hresp_okay", hresp_bad, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
